// File: rtl/stack_controller.sv
// Stack controller: sequences PUSH/POP against a shared data memory, owns the
// downward-growing stack pointer and reports overflow/underflow rejections.
module stack_controller #(
    parameter int DATA_W      = 16,
    parameter int STACK_TOP   = 64,
    parameter int STACK_LIMIT = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              i_clock,
    input  logic              i_resetn,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_dIn,
    output logic [DATA_W-1:0] o_dOut,
    output logic [15:0]       o_sp,
    output logic [15:0]       o_depth,
    output logic [15:0]       o_memAddr,
    output logic              o_memWr,
    output logic [DATA_W-1:0] o_memDout,
    input  logic [DATA_W-1:0] i_memDin,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam logic [15:0] SP_TOP   = 16'(STACK_TOP);
    localparam logic [15:0] SP_LIMIT = 16'(STACK_LIMIT);
    localparam int          CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH_DEC,
        S_PUSH_WR,
        S_POP_RD,
        S_POP_WAIT,
        S_POP_INC,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [15:0]       r_sp;
    logic [DATA_W-1:0] r_dOut;
    logic [DATA_W-1:0] r_wrData;
    logic [CNT_W-1:0]  r_latCnt;
    logic              r_done;
    logic              r_overflow;
    logic              r_underflow;
    logic              r_pendOvf;
    logic              r_pendUnf;

    logic w_memPhase;

    // Rejected requests still pass through DONE so every Done pulse comes off the same edge.
    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_state     <= S_IDLE;
            r_sp        <= SP_TOP;
            r_dOut      <= '0;
            r_wrData    <= '0;
            r_latCnt    <= '0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_pendOvf   <= 1'b0;
            r_pendUnf   <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_pendOvf <= 1'b0;
                    r_pendUnf <= 1'b0;
                    if (i_push && !i_pop) begin
                        if (r_sp == SP_LIMIT) begin
                            r_pendOvf <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_wrData <= i_dIn;
                            r_state  <= S_PUSH_DEC;
                        end
                    end else if (i_pop && !i_push) begin
                        if (r_sp == SP_TOP) begin
                            r_pendUnf <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_state <= S_POP_RD;
                        end
                    end
                end
                S_PUSH_DEC: begin
                    r_sp    <= r_sp - 16'd1;
                    r_state <= S_PUSH_WR;
                end
                S_PUSH_WR: begin
                    r_state <= S_DONE;
                end
                S_POP_RD: begin
                    r_latCnt <= LAT_LOAD;
                    r_state  <= S_POP_WAIT;
                end
                S_POP_WAIT: begin
                    if (r_latCnt == '0) begin
                        r_dOut  <= i_memDin;
                        r_state <= S_POP_INC;
                    end else begin
                        r_latCnt <= r_latCnt - 1'b1;
                    end
                end
                S_POP_INC: begin
                    r_sp    <= r_sp + 16'd1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done      <= 1'b1;
                    r_overflow  <= r_pendOvf;
                    r_underflow <= r_pendUnf;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_memPhase = (r_state == S_PUSH_WR) || (r_state == S_POP_RD) || (r_state == S_POP_WAIT);

    // Write enable is gated by reset so an aborted push never reaches memory.
    assign o_memWr     = (r_state == S_PUSH_WR) && i_resetn;
    assign o_memAddr   = w_memPhase ? r_sp : 16'd0;
    assign o_memDout   = r_wrData;
    assign o_dOut      = r_dOut;
    assign o_sp        = r_sp;
    assign o_depth     = SP_TOP - r_sp;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_stack_controller.sv
// Self-checking bench for stack_controller: scoreboard of expected operation
// results checked against two instances (memory latency 1 and 3).
module tb_stack_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic aResetn = 1'b0;

    logic        aPush = 1'b0, aPop = 1'b0;
    logic [15:0] aDIn = '0;
    logic [15:0] aDOut, aSp, aDepth, aMemAddr, aMemDout, aMemDin;
    logic        aMemWr, aBusy, aDone, aOvf, aUnf;

    logic        bPush = 1'b0, bPop = 1'b0;
    logic [15:0] bDIn = '0;
    logic [15:0] bDOut, bSp, bDepth, bMemAddr, bMemDout, bMemDin;
    logic        bMemWr, bBusy, bDone, bOvf, bUnf;

    stack_controller #(.DATA_W(16), .STACK_TOP(64), .STACK_LIMIT(32), .MEM_LATENCY(1)) dutA (
        .i_clock(clk), .i_resetn(aResetn), .i_push(aPush), .i_pop(aPop), .i_dIn(aDIn),
        .o_dOut(aDOut), .o_sp(aSp), .o_depth(aDepth), .o_memAddr(aMemAddr), .o_memWr(aMemWr),
        .o_memDout(aMemDout), .i_memDin(aMemDin), .o_busy(aBusy), .o_done(aDone),
        .o_overflow(aOvf), .o_underflow(aUnf)
    );

    stack_controller #(.DATA_W(16), .STACK_TOP(64), .STACK_LIMIT(32), .MEM_LATENCY(3)) dutB (
        .i_clock(clk), .i_resetn(aResetn), .i_push(bPush), .i_pop(bPop), .i_dIn(bDIn),
        .o_dOut(bDOut), .o_sp(bSp), .o_depth(bDepth), .o_memAddr(bMemAddr), .o_memWr(bMemWr),
        .o_memDout(bMemDout), .i_memDin(bMemDin), .o_busy(bBusy), .o_done(bDone),
        .o_overflow(bOvf), .o_underflow(bUnf)
    );

    // Memory models: synchronous read with 1-cycle and 3-cycle latency.
    logic [15:0] memA [0:127];
    logic [15:0] memB [0:127];
    logic [15:0] pipeA, pipeB0, pipeB1, pipeB2;

    always @(posedge clk) begin
        if (aMemWr) memA[aMemAddr[6:0]] <= aMemDout;
        pipeA <= memA[aMemAddr[6:0]];
        if (bMemWr) memB[bMemAddr[6:0]] <= bMemDout;
        pipeB0 <= memB[bMemAddr[6:0]];
        pipeB1 <= pipeB0;
        pipeB2 <= pipeB1;
    end
    assign aMemDin = pipeA;
    assign bMemDin = pipeB2;

    typedef struct {
        int          lat;
        int          doneCnt;
        logic        ovf;
        logic        unf;
        int          wr;
        logic [15:0] wrAddr;
        logic [15:0] wrData;
        logic [15:0] sp;
        logic [15:0] dout;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    int          modelSp = 64;
    logic [15:0] modelDout = '0;
    logic [15:0] modelMem [0:127];

    int          obsLat, obsDoneCnt, obsWr;
    logic        obsOvf, obsUnf;
    logic [15:0] obsWrAddr, obsWrData, obsSp, obsDOut, obsDepth;

    task automatic predict(input logic push, input logic pop, input logic [15:0] din);
        exp_t e;
        e.lat = 0; e.doneCnt = 0; e.ovf = 1'b0; e.unf = 1'b0;
        e.wr = 0; e.wrAddr = '0; e.wrData = '0;
        if (push && !pop) begin
            if (modelSp == 32) begin
                e.ovf = 1'b1; e.lat = 1;
            end else begin
                modelSp = modelSp - 1;
                modelMem[modelSp] = din;
                e.wr = 1; e.wrAddr = 16'(modelSp); e.wrData = din; e.lat = 3;
            end
        end else if (pop && !push) begin
            if (modelSp == 64) begin
                e.unf = 1'b1; e.lat = 1;
            end else begin
                modelDout = modelMem[modelSp];
                modelSp = modelSp + 1;
                e.lat = 4;
            end
        end
        if (e.lat != 0) e.doneCnt = 1;
        e.sp = 16'(modelSp);
        e.dout = modelDout;
        sb.push_back(e);
    endtask

    // Drives one request on instance A and records what the DUT did.
    task automatic runOp(input logic push, input logic pop, input logic [15:0] din,
                         input bit holdBusy, input int budget);
        predict(push, pop, din);
        aPush = push; aPop = pop; aDIn = din;
        @(posedge clk); #1;
        aPush = holdBusy & aBusy; aPop = 1'b0; aDIn = 16'hFFFF;
        obsLat = 0; obsDoneCnt = 0; obsWr = 0; obsOvf = 1'b0; obsUnf = 1'b0;
        obsWrAddr = '0; obsWrData = '0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(posedge clk); #1;
            if (aMemWr) begin
                obsWr++; obsWrAddr = aMemAddr; obsWrData = aMemDout;
            end
            if (aDone) begin
                obsDoneCnt++;
                if (obsLat == 0) begin
                    obsLat = cyc; obsOvf = aOvf; obsUnf = aUnf;
                end
            end
            aPush = holdBusy & aBusy;
        end
        aPush = 1'b0;
        obsSp = aSp; obsDOut = aDOut; obsDepth = aDepth;
    endtask

    task automatic doReset();
        aResetn = 1'b0; aPush = 1'b0; aPop = 1'b0; bPush = 1'b0; bPop = 1'b0;
        repeat (2) @(posedge clk);
        #1 aResetn = 1'b1;
        modelSp = 64; modelDout = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        doReset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (aSp !== 16'd64) begin bad++; $display("[TB] FAIL reset_sp got=%0d want=64", aSp); end
        total++; if (aDepth !== 16'd0) begin bad++; $display("[TB] FAIL reset_depth got=%0d want=0", aDepth); end
        total++; if (aBusy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", aBusy); end
        total++; if (aMemWr !== 1'b0) begin bad++; $display("[TB] FAIL reset_memwr got=%b want=0", aMemWr); end
        total++; if (aDOut !== 16'd0) begin bad++; $display("[TB] FAIL reset_dout got=%h want=0", aDOut); end
        total++; if (aDone !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", aDone); end
    endtask

    // Runs a table of operations on instance A, comparing each against the scoreboard.
    task automatic runTable(input string name, input logic pushes[], input logic pops[],
                            input logic [15:0] dins[], input bit holds[]);
        exp_t e;
        for (int i = 0; i < pushes.size(); i++) begin
            runOp(pushes[i], pops[i], dins[i], holds[i], 8);
            e = sb.pop_front();
            total++; if (obsLat !== e.lat) begin bad++; $display("[TB] FAIL %s[%0d] latency got=%0d want=%0d", name, i, obsLat, e.lat); end
            total++; if (obsDoneCnt !== e.doneCnt) begin bad++; $display("[TB] FAIL %s[%0d] done_count got=%0d want=%0d", name, i, obsDoneCnt, e.doneCnt); end
            total++; if (obsOvf !== e.ovf) begin bad++; $display("[TB] FAIL %s[%0d] overflow got=%b want=%b", name, i, obsOvf, e.ovf); end
            total++; if (obsUnf !== e.unf) begin bad++; $display("[TB] FAIL %s[%0d] underflow got=%b want=%b", name, i, obsUnf, e.unf); end
            total++; if (obsWr !== e.wr) begin bad++; $display("[TB] FAIL %s[%0d] write_count got=%0d want=%0d", name, i, obsWr, e.wr); end
            if (e.wr != 0) begin
                total++; if (obsWrAddr !== e.wrAddr) begin bad++; $display("[TB] FAIL %s[%0d] write_addr got=%0d want=%0d", name, i, obsWrAddr, e.wrAddr); end
                total++; if (obsWrData !== e.wrData) begin bad++; $display("[TB] FAIL %s[%0d] write_data got=%h want=%h", name, i, obsWrData, e.wrData); end
            end
            total++; if (obsSp !== e.sp) begin bad++; $display("[TB] FAIL %s[%0d] sp got=%0d want=%0d", name, i, obsSp, e.sp); end
            total++; if (obsDepth !== (16'd64 - e.sp)) begin bad++; $display("[TB] FAIL %s[%0d] depth got=%0d want=%0d", name, i, obsDepth, 16'd64 - e.sp); end
            total++; if (obsDOut !== e.dout) begin bad++; $display("[TB] FAIL %s[%0d] dout got=%h want=%h", name, i, obsDOut, e.dout); end
        end
    endtask

    task automatic test_single_push();
        runTable("single_push", '{1'b1}, '{1'b0}, '{16'hA5A5}, '{1'b0});
    endtask

    task automatic test_push_pop_order();
        doReset();
        runTable("push_pop_order",
                 '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
                 '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1},
                 '{16'd1, 16'd2, 16'd3, 16'd0, 16'd0, 16'd0},
                 '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_boundaries();
        logic        pushes[] = new[34];
        logic        pops[] = new[34];
        logic [15:0] dins[] = new[34];
        bit          holds[] = new[34];
        doReset();
        pushes[0] = 1'b0; pops[0] = 1'b1; dins[0] = 16'h0; holds[0] = 1'b0;
        for (int i = 1; i < 34; i++) begin
            pushes[i] = 1'b1; pops[i] = 1'b0; holds[i] = 1'b0;
            dins[i] = 16'($urandom_range(0, 65535));
        end
        runTable("boundaries", pushes, pops, dins, holds);
    endtask

    task automatic test_back_to_back();
        doReset();
        runTable("noop_and_busy", '{1'b1, 1'b1}, '{1'b1, 1'b0}, '{16'h1111, 16'h5A5A}, '{1'b0, 1'b1});
    endtask

    task automatic test_reset_abort();
        logic [15:0] saved;
        aPush = 1'b1; aDIn = 16'hBEEF;
        @(posedge clk); #1;
        aPush = 1'b0;
        @(posedge clk); #1;
        total++; if (aMemWr !== 1'b1) begin bad++; $display("[TB] FAIL abort_in_push_wr memwr got=%b want=1", aMemWr); end
        saved = memA[aMemAddr[6:0]];
        aResetn = 1'b0;
        #1;
        total++; if (aMemWr !== 1'b0) begin bad++; $display("[TB] FAIL abort_memwr_gated got=%b want=0", aMemWr); end
        @(posedge clk); #1;
        aResetn = 1'b1;
        modelSp = 64; modelDout = '0;
        total++; if (aSp !== 16'd64) begin bad++; $display("[TB] FAIL abort_sp got=%0d want=64", aSp); end
        total++; if (aBusy !== 1'b0) begin bad++; $display("[TB] FAIL abort_idle busy got=%b want=0", aBusy); end
        total++; if (aDOut !== 16'd0) begin bad++; $display("[TB] FAIL abort_dout got=%h want=0", aDOut); end
        total++; if (memA[62] !== saved) begin bad++; $display("[TB] FAIL abort_no_write mem got=%h want=%h", memA[62], saved); end
    endtask

    task automatic test_latency3();
        exp_t e;
        int   lat;
        e.lat = 3; e.doneCnt = 1; e.ovf = 1'b0; e.unf = 1'b0; e.wr = 1;
        e.wrAddr = 16'd63; e.wrData = 16'h1234; e.sp = 16'd63; e.dout = 16'h0;
        sb.push_back(e);
        bPush = 1'b1; bDIn = 16'h1234;
        @(posedge clk); #1;
        bPush = 1'b0;
        lat = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk); #1;
            if (bDone && lat == 0) lat = cyc;
        end
        e = sb.pop_front();
        total++; if (lat !== e.lat) begin bad++; $display("[TB] FAIL lat3_push latency got=%0d want=%0d", lat, e.lat); end
        total++; if (bSp !== e.sp) begin bad++; $display("[TB] FAIL lat3_push sp got=%0d want=%0d", bSp, e.sp); end

        e.lat = 6; e.wr = 0; e.sp = 16'd64; e.dout = 16'h1234;
        sb.push_back(e);
        bPop = 1'b1;
        @(posedge clk); #1;
        bPop = 1'b0;
        lat = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk); #1;
            if (bDone && lat == 0) lat = cyc;
        end
        e = sb.pop_front();
        total++; if (lat !== e.lat) begin bad++; $display("[TB] FAIL lat3_pop latency got=%0d want=%0d", lat, e.lat); end
        total++; if (bDOut !== e.dout) begin bad++; $display("[TB] FAIL lat3_pop dout got=%h want=%h", bDOut, e.dout); end
        total++; if (bSp !== e.sp) begin bad++; $display("[TB] FAIL lat3_pop sp got=%0d want=%0d", bSp, e.sp); end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_push_pop_order();
        test_boundaries();
        test_back_to_back();
        test_reset_abort();
        test_latency3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
